muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, fixed latency.
// Shift-add multiply and restoring divide share one double-width accumulator.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            regwrite_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
        return (~v) + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_t              state_r;
    state_t              next_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [2:0]          op_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     mcand_r;
    logic                neg_q_r;
    logic                neg_r_r;
    logic                div0_r;
    logic [4:0]          rd_r;
    logic                busy_r;
    logic                done_r;
    logic [XLEN-1:0]     result_r;
    logic [4:0]          rd_out_r;
    logic                regwrite_r;

    logic                a_signed_s;
    logic                b_signed_s;
    logic                a_neg_s;
    logic                b_neg_s;
    logic [XLEN-1:0]     a_mag_s;
    logic [XLEN-1:0]     b_mag_s;
    logic [XLEN:0]       sum_s;
    logic [XLEN:0]       shl_s;
    logic [XLEN:0]       diff_s;
    logic [2*XLEN-1:0]   acc_next_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     fin_s;

    // Operand sign decode and magnitude conversion for the request being sampled
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            OP_MULHSU: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        a_neg_s = a_signed_s & rs1_data[XLEN-1];
        b_neg_s = b_signed_s & rs2_data[XLEN-1];
        a_mag_s = a_neg_s ? neg_w(rs1_data) : rs1_data;
        b_mag_s = b_neg_s ? neg_w(rs2_data) : rs2_data;
    end

    // One radix-2 step: acc holds {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]}
               + (acc_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
        shl_s  = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        diff_s = shl_s - {1'b0, mcand_r};
        if (op_r[2]) begin
            if (!diff_s[XLEN]) begin
                acc_next_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_next_s = {shl_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next_s = {sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Final sign fix-up and result selection from the last step's accumulator
    always_comb begin
        prod_s = neg_q_r ? neg_dw(acc_next_s) : acc_next_s;
        case (op_r)
            OP_MUL:                      fin_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (div0_r) begin
                    fin_s = {XLEN{1'b1}};
                end else if (neg_q_r) begin
                    fin_s = neg_w(acc_next_s[XLEN-1:0]);
                end else begin
                    fin_s = acc_next_s[XLEN-1:0];
                end
            end
            OP_REM, OP_REMU: begin
                // A zero divisor leaves |A| in the remainder, so the sign fix restores A
                if (neg_r_r) begin
                    fin_s = neg_w(acc_next_s[2*XLEN-1:XLEN]);
                end else begin
                    fin_s = acc_next_s[2*XLEN-1:XLEN];
                end
            end
            default: fin_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_s = CALC;
                end else begin
                    next_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == LAST_CNT) begin
                    next_s = DONE;
                end else begin
                    next_s = CALC;
                end
            end
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State register, operand latches, accumulator and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 3'd0;
            acc_r   <= {(2*XLEN){1'b0}};
            mcand_r <= {XLEN{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            div0_r  <= 1'b0;
            rd_r    <= 5'd0;
        end else begin
            state_r <= next_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r    <= op;
                        rd_r    <= rd_in;
                        cnt_r   <= {CNT_W{1'b0}};
                        neg_q_r <= a_neg_s ^ b_neg_s;
                        neg_r_r <= a_neg_s;
                        div0_r  <= (rs2_data == {XLEN{1'b0}});
                        if (op[2]) begin
                            acc_r   <= {{XLEN{1'b0}}, a_mag_s};
                            mcand_r <= b_mag_s;
                        end else begin
                            acc_r   <= {{XLEN{1'b0}}, b_mag_s};
                            mcand_r <= a_mag_s;
                        end
                    end
                end
                CALC: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered handshake outputs; result and rd_out load only when entering DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            regwrite_r <= 1'b0;
            result_r   <= {XLEN{1'b0}};
            rd_out_r   <= 5'd0;
        end else begin
            busy_r     <= (next_s != IDLE);
            done_r     <= (next_s == DONE);
            regwrite_r <= (next_s == DONE) && (rd_r != 5'd0);
            if ((state_r == CALC) && (cnt_r == LAST_CNT)) begin
                result_r <= fin_s;
                rd_out_r <= rd_r;
            end else begin
                result_r <= result_r;
                rd_out_r <= rd_out_r;
            end
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign regwrite_out = regwrite_r;
    assign result       = result_r;
    assign rd_out       = rd_out_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: RV32M results, fixed latency,
// start-while-busy, mid-operation reset, rd=0 and back-to-back operations.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        regwrite_out;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rd_in        (rd_in),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .rd_out       (rd_out),
        .regwrite_out (regwrite_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait for done; latency counts posedges including the sampling edge.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int edges;
        logic busy_ok;
        @(negedge clk);
        op = o; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && edges < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, " latency"}, 32'(edges), 32'd33);
        check({tag, " result"}, result, exp);
        check({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
        check({tag, " regwrite"}, {31'd0, regwrite_out}, {31'd0, (rd != 5'd0)});
        check({tag, " busy_calc"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " busy_done"}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        int edges;
        int pulses;
        int lat;
        logic [31:0] res;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result", result, 32'd0);
        check("rst rd_out", {27'd0, rd_out}, 32'd0);
        check("rst regwrite", {31'd0, regwrite_out}, 32'd0);
        rst = 1'b0;

        do_op("mul7x6",      3'd0, 32'd7,          32'd6,          5'd5,  32'd42);
        do_op("mulh-1",      3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000);
        do_op("mulhu-1",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE);
        do_op("mulhsu-1",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'hFFFF_FFFF);
        do_op("mulh_min",    3'd1, 32'h8000_0000,  32'h8000_0000,  5'd6,  32'h4000_0000);
        do_op("mul_big",     3'd0, 32'h1234_5678,  32'd9,          5'd7,  32'hA3D7_0A38);
        do_op("div-7/2",     3'd4, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFD);
        do_op("rem-7/2",     3'd6, 32'hFFFF_FFF9,  32'd2,          5'd9,  32'hFFFF_FFFF);
        do_op("div20/-3",    3'd4, 32'd20,         32'hFFFF_FFFD,  5'd10, 32'hFFFF_FFFA);
        do_op("rem20/-3",    3'd6, 32'd20,         32'hFFFF_FFFD,  5'd11, 32'd2);
        do_op("divu100/0",   3'd5, 32'd100,        32'd0,          5'd12, 32'hFFFF_FFFF);
        do_op("remu100/0",   3'd7, 32'd100,        32'd0,          5'd13, 32'd100);
        do_op("div-5/0",     3'd4, 32'hFFFF_FFFB,  32'd0,          5'd14, 32'hFFFF_FFFF);
        do_op("rem-5/0",     3'd6, 32'hFFFF_FFFB,  32'd0,          5'd15, 32'hFFFF_FFFB);
        do_op("divu_max/16", 3'd5, 32'hFFFF_FFFF,  32'd16,         5'd16, 32'h0FFF_FFFF);
        do_op("remu_max/16", 3'd7, 32'hFFFF_FFFF,  32'd16,         5'd17, 32'd15);
        do_op("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd18, 32'h8000_0000);
        do_op("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd19, 32'd0);

        // Start pulsed again at counter 10 must be ignored
        @(negedge clk);
        op = 3'd0; rs1_data = 32'd5; rs2_data = 32'd5; rd_in = 5'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        edges = 1; pulses = 0; lat = 0; res = 32'd0;
        for (int i = 0; i < 80; i++) begin
            if (edges == 11) begin
                start = 1'b1; rs1_data = 32'd2; rs2_data = 32'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                lat = edges;
                res = result;
            end
        end
        check("ignore pulses", 32'(pulses), 32'd1);
        check("ignore latency", 32'(lat), 32'd33);
        check("ignore result", res, 32'd25);

        // Reset in the middle of CALC aborts without a done pulse
        @(negedge clk);
        op = 3'd0; rs1_data = 32'd4; rs2_data = 32'd4; rd_in = 5'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort rd_out", {27'd0, rd_out}, 32'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("abort no_done", 32'(pulses), 32'd0);
        do_op("mul3x3", 3'd0, 32'd3, 32'd3, 5'd9, 32'd9);

        // rd=0 completes without regwrite, then an immediate back-to-back op
        do_op("rd0", 3'd0, 32'd11, 32'd3, 5'd0, 32'd33);
        do_op("b2b divu", 3'd5, 32'd50, 32'd7, 5'd4, 32'd7);
        @(negedge clk);
        check("post done", {31'd0, done}, 32'd0);
        check("post regwrite", {31'd0, regwrite_out}, 32'd0);
        check("post busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        check("hold result", result, 32'd7);
        check("hold rd_out", {27'd0, rd_out}, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
